imem_load_fetch_ctrl: RTL and testbench

Sequencing controller for the MIPS pipeline instruction memory. After reset it accepts a program image over a valid/ready loader stream and writes it word-by-word into a DEPTH-word store, zero-filling unused words. It then serves the fetch stage with a registered, word-addressed read.
- Byte address is divided by 4.
- Misaligned or out-of-range fetches are flagged.
- Fetch is stalled while loading.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_array.sv | 40 ++++
 rtl/imem_load_fetch_ctrl.sv | 159 +++++++++++++++
 tb/tb_imem_load_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// ============================================================================
// Module : imem_pkg
// Brief  : Shared types and constants for the instruction-memory controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam word_t C_NOP_WORD = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/imem_array.sv
// ============================================================================
// Module : imem_array
// Brief  : DEPTH x 32 storage, one synchronous write port, registered read.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  word_t         i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output word_t         o_rdata
);

    word_t r_mem [DEPTH];
    word_t r_rdata;

    // Contents are deliberately not reset; the loader rewrites every word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/imem_load_fetch_ctrl.sv
// ============================================================================
// Module : imem_load_fetch_ctrl
// Brief  : Loads a program image into instruction memory, zero-fills the rest,
//          then serves word-addressed fetches. Optional fault counter is
//          enabled by defining IMEM_FAULT_CNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_load_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int    DEPTH    = 32,
    parameter int    AW       = $clog2(DEPTH),
    parameter word_t NOP_WORD = C_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic        reload,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        ins_valid,
    output logic [31:0] ins_out,
    output logic        fetch_fault,
    output logic        boot_done
`ifdef IMEM_FAULT_CNT_EN
    ,
    output logic [7:0]  fault_cnt
`endif
);

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] w_next_ptr;
    logic          w_ptr_last;
    logic          w_we;
    word_t         w_wdata;
    logic          w_fault;
    word_t         w_rdata;
    logic          r_ins_valid;
    logic          r_fault;
    logic          r_have_data;

    assign w_ptr_last = (r_wr_ptr == AW'(DEPTH - 1));
    assign w_fault    = (fetch_addr[1:0] != 2'b00) ||
                        ({2'b00, fetch_addr[31:2]} >= 32'(DEPTH));

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_wr_ptr;
        w_we         = 1'b0;
        w_wdata      = ld_data;
        ld_ready     = 1'b0;
        fetch_gnt    = 1'b0;
        if (reload) begin
            w_next_state = ST_LOAD;
            w_next_ptr   = '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    ld_ready = 1'b1;
                    if (ld_valid) begin
                        w_we       = 1'b1;
                        w_next_ptr = r_wr_ptr + 1'b1;
                        // A full store ends the load even without ld_last.
                        if (w_ptr_last) begin
                            w_next_state = ST_RUN;
                        end else if (ld_last) begin
                            w_next_state = ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    w_we       = 1'b1;
                    w_wdata    = NOP_WORD;
                    w_next_ptr = r_wr_ptr + 1'b1;
                    if (w_ptr_last) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    fetch_gnt = fetch_req;
                end
                default: begin
                    w_next_state = ST_LOAD;
                    w_next_ptr   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_LOAD;
            r_wr_ptr <= '0;
        end else begin
            r_state  <= w_next_state;
            r_wr_ptr <= w_next_ptr;
        end
    end

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_re    (fetch_gnt),
        .i_raddr (fetch_addr[AW+1:2]),
        .o_rdata (w_rdata)
    );

    // Fault and data-present flags only update on a grant so ins_out holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ins_valid <= 1'b0;
            r_fault     <= 1'b0;
            r_have_data <= 1'b0;
        end else begin
            r_ins_valid <= fetch_gnt;
            if (fetch_gnt) begin
                r_fault     <= w_fault;
                r_have_data <= 1'b1;
            end
        end
    end

    assign ins_valid   = r_ins_valid;
    assign fetch_fault = r_fault;
    assign ins_out     = (r_have_data && !r_fault) ? w_rdata : NOP_WORD;
    assign boot_done   = (r_state == ST_RUN);

`ifdef IMEM_FAULT_CNT_EN
    logic [7:0] r_fault_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fault_cnt <= 8'h00;
        end else if (reload) begin
            r_fault_cnt <= 8'h00;
        end else if (r_ins_valid && r_fault && (r_fault_cnt != 8'hFF)) begin
            r_fault_cnt <= r_fault_cnt + 8'h01;
        end
    end

    assign fault_cnt = r_fault_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_load_fetch_ctrl.sv
// ============================================================================
// Module : tb_imem_load_fetch_ctrl
// Brief  : Directed, table-driven bench for imem_load_fetch_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_load_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        reload;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic        fetch_fault;
    logic        boot_done;
`ifdef IMEM_FAULT_CNT_EN
    logic [7:0]  fault_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imem_load_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .reload      (reload),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .ins_valid   (ins_valid),
        .ins_out     (ins_out),
        .fetch_fault (fetch_fault),
        .boot_done   (boot_done)
`ifdef IMEM_FAULT_CNT_EN
        ,
        .fault_cnt   (fault_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_image(input int n, input logic [31:0] base, input bit stall);
        for (int i = 0; i < n; i++) begin
            ld_valid  = 1'b1;
            ld_data   = base + 32'(i);
            ld_last   = (i == n - 1);
            fetch_req = stall;
            #1;
            chk("ld_ready", {31'b0, ld_ready}, 32'd1);
            if (stall) chk("stall_gnt", {31'b0, fetch_gnt}, 32'd0);
            cyc();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_boot(input int exp_edges, input string nm);
        int n = 0;
        while (boot_done !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        chk(nm, 32'(n), 32'(exp_edges));
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input logic fault, input string nm);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        #1;
        chk({nm, "_gnt"}, {31'b0, fetch_gnt}, 32'd1);
        cyc();
        fetch_req = 1'b0;
        chk({nm, "_valid"}, {31'b0, ins_valid}, 32'd1);
        chk({nm, "_data"}, ins_out, data);
        chk({nm, "_fault"}, {31'b0, fetch_fault}, {31'b0, fault});
    endtask

    task automatic do_reload();
        reload = 1'b1;
        cyc();
        reload = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h1000_0000, 1'b0};
        vecs[1] = '{32'h0000_0040, 32'h1000_0010, 1'b0};
        vecs[2] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h0000_0080, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h0000_0004, 32'h1000_0001, 1'b0};
        vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};

        rst = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        reload = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        cyc(); cyc();
        rst = 1'b1;
        #1;
        chk("rst_boot_done", {31'b0, boot_done}, 32'd0);
        chk("rst_ins_valid", {31'b0, ins_valid}, 32'd0);
        chk("rst_ins_out", ins_out, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
        chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
`ifdef IMEM_FAULT_CNT_EN
        chk("rst_fault_cnt", {24'b0, fault_cnt}, 32'd0);
`endif

        // Full image, fetch held high the whole load: RUN with no FILL.
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        ld_data  = 32'hDEAD_0000;
        #1;
        chk("last_ignored_pre", {31'b0, boot_done}, 32'd0);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        cyc();
        load_image(32, 32'h1000_0000, 1'b1);
        chk("full_boot_done", {31'b0, boot_done}, 32'd1);
        fetch(32'h0000_007C, 32'h1000_001F, 1'b0, "full_7c");

        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i].addr, vecs[i].data, vecs[i].fault, $sformatf("vec%0d", i));
            cyc();
            chk($sformatf("vec%0d_idle_valid", i), {31'b0, ins_valid}, 32'd0);
            chk($sformatf("vec%0d_hold", i), ins_out, vecs[i].data);
        end
`ifdef IMEM_FAULT_CNT_EN
        chk("fault_cnt", {24'b0, fault_cnt}, 32'd3);
`endif

        // Back-to-back grants.
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        #1;
        chk("b2b_gnt", {31'b0, fetch_gnt}, 32'd1);
        cyc();
        fetch_addr = 32'h4;
        chk("b2b0_valid", {31'b0, ins_valid}, 32'd1);
        chk("b2b0_data", ins_out, 32'h1000_0000);
        cyc();
        fetch_addr = 32'h8;
        chk("b2b1_valid", {31'b0, ins_valid}, 32'd1);
        chk("b2b1_data", ins_out, 32'h1000_0001);
        cyc();
        fetch_req = 1'b0;
        chk("b2b2_valid", {31'b0, ins_valid}, 32'd1);
        chk("b2b2_data", ins_out, 32'h1000_0002);
        cyc();
        chk("b2b_end_valid", {31'b0, ins_valid}, 32'd0);

        // Short image: 3 words then 29 fill cycles.
        do_reload();
        chk("reload_boot_done", {31'b0, boot_done}, 32'd0);
`ifdef IMEM_FAULT_CNT_EN
        chk("reload_fault_cnt", {24'b0, fault_cnt}, 32'd0);
`endif
        load_image(3, 32'hA000_0000, 1'b0);
        chk("short_ld_ready_fill", {31'b0, ld_ready}, 32'd0);
        wait_boot(29, "short_fill_cycles");
        fetch(32'h0000_0008, 32'hA000_0002, 1'b0, "short_08");
        fetch(32'h0000_000C, 32'h0000_0000, 1'b0, "short_0c");

        // Reload in RUN while fetch_req is high.
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        cyc();
        reload     = 1'b1;
        fetch_addr = 32'h8;
        #1;
        chk("rl_gnt", {31'b0, fetch_gnt}, 32'd0);
        chk("rl_prev_valid", {31'b0, ins_valid}, 32'd1);
        chk("rl_prev_data", ins_out, 32'hA000_0001);
        cyc();
        reload    = 1'b0;
        fetch_req = 1'b0;
        chk("rl_boot_done", {31'b0, boot_done}, 32'd0);
        chk("rl_no_valid", {31'b0, ins_valid}, 32'd0);
        load_image(1, 32'hDEAD_BEEF, 1'b0);
        wait_boot(31, "one_fill_cycles");
        fetch(32'h0, 32'hDEAD_BEEF, 1'b0, "one_00");
        fetch(32'h4, 32'h0, 1'b0, "one_04");

        // Async reset while a result is presented.
        fetch(32'h0, 32'hDEAD_BEEF, 1'b0, "pre_rst");
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'b0, ins_valid}, 32'd0);
        chk("arst_boot", {31'b0, boot_done}, 32'd0);
        chk("arst_out", ins_out, 32'h0);
        #1;
        rst = 1'b1;
        cyc();

        // Async reset mid-LOAD.
        ld_valid = 1'b1;
        ld_data  = 32'h5555_5555;
        cyc();
        ld_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_boot", {31'b0, boot_done}, 32'd0);
        chk("mid_valid", {31'b0, ins_valid}, 32'd0);
        #1;
        rst = 1'b1;
        cyc();

        // A word offered with reload is not accepted.
        ld_valid = 1'b1;
        ld_data  = 32'hBAD0_BAD0;
        reload   = 1'b1;
        #1;
        chk("rl_ld_ready", {31'b0, ld_ready}, 32'd0);
        cyc();
        reload   = 1'b0;
        ld_valid = 1'b0;
        load_image(2, 32'h1234_0000, 1'b0);
        wait_boot(30, "two_fill_cycles");
        fetch(32'h0, 32'h1234_0000, 1'b0, "two_00");
        fetch(32'h4, 32'h1234_0001, 1'b0, "two_04");
        fetch(32'h8, 32'h0, 1'b0, "two_08");

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
